// File: rtl/mem_arbiter_if.sv
// One cache-to-memory block port: request strobes, block address and data, completion.
// The master drives requests and the slave answers them.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;

  modport master (output read, write, addr, wdata, input rdata, ready);
  modport slave  (input read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache and the D-cache, one grant at a time.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the D-cache wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic           clk,
  input  logic           proc_reset,
  mem_arbiter_if.slave   i_mem,
  mem_arbiter_if.slave   d_mem,
  mem_arbiter_if.master  mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;
  typedef enum logic {SIDE_I = 1'b0, SIDE_D = 1'b1} side_t;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  state_t state;
  side_t  last_gnt;
  logic   i_active;
  logic   d_active;
  logic   tie_to_d;
  logic   gnt_i;
  logic   gnt_d;

  assign i_active = i_mem.read | i_mem.write;
  assign d_active = d_mem.read | d_mem.write;
  assign tie_to_d = RR_EN ? (last_gnt == SIDE_I) : 1'b1;

  // A grant is held until memory completes or the owner withdraws both strobes.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state    <= IDLE;
      last_gnt <= SIDE_I;
    end else begin
      case (state)
        IDLE: begin
          if (d_active && (!i_active || tie_to_d)) begin
            state    <= GNT_D;
            last_gnt <= SIDE_D;
          end else if (i_active) begin
            state    <= GNT_I;
            last_gnt <= SIDE_I;
          end
        end
        GNT_I: if (mem.ready || !i_active) state <= IDLE;
        GNT_D: if (mem.ready || !d_active) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign gnt_i = (state == GNT_I);
  assign gnt_d = (state == GNT_D);

  // Request path is a live mux of the owner's signals; return path is steered to the owner only.
  assign mem.read  = gnt_i ? i_mem.read  : (gnt_d ? d_mem.read  : 1'b0);
  assign mem.write = gnt_i ? i_mem.write : (gnt_d ? d_mem.write : 1'b0);
  assign mem.addr  = gnt_i ? i_mem.addr  : (gnt_d ? d_mem.addr  : {ADDR_W{1'b0}});
  assign mem.wdata = gnt_i ? i_mem.wdata : (gnt_d ? d_mem.wdata : {DATA_W{1'b0}});

  assign i_mem.ready = gnt_i & mem.ready;
  assign d_mem.ready = gnt_d & mem.ready;
  assign i_mem.rdata = gnt_i ? mem.rdata : {DATA_W{1'b0}};
  assign d_mem.rdata = gnt_d ? mem.rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed sequences, a tie-breaking vector table
// and randomized traffic checked against a transaction-level ownership model.
module tb_mem_arbiter;

  localparam int ADDR_W   = 28;
  localparam int DATA_W   = 128;
  localparam int VW       = 2 + ADDR_W + 3 * DATA_W + 2;
  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;

`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct {
    logic ir;
    logic iw;
    logic dr;
    logic dw;
    int   exp_owner;
  } vec_t;

  logic clk;
  logic proc_reset;
  int   checks;
  int   failures;
  int   m_owner;
  int   m_last;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) i_bus ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) d_bus ();
  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m_bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .i_mem      (i_bus),
    .d_mem      (d_bus),
    .mem        (m_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What every DUT output should be when the given side owns the memory port.
  function automatic logic [VW-1:0] expect_out(input int owner);
    logic              mr, mw, ir_rdy, dr_rdy;
    logic [ADDR_W-1:0] ma;
    logic [DATA_W-1:0] mwd, ird, drd;
    mr = 1'b0; mw = 1'b0; ma = '0; mwd = '0;
    ir_rdy = 1'b0; ird = '0; dr_rdy = 1'b0; drd = '0;
    if (owner == OWN_I) begin
      mr = i_bus.read; mw = i_bus.write; ma = i_bus.addr; mwd = i_bus.wdata;
      ir_rdy = m_bus.ready; ird = m_bus.rdata;
    end else if (owner == OWN_D) begin
      mr = d_bus.read; mw = d_bus.write; ma = d_bus.addr; mwd = d_bus.wdata;
      dr_rdy = m_bus.ready; drd = m_bus.rdata;
    end
    return {mr, mw, ma, mwd, ir_rdy, ird, dr_rdy, drd};
  endfunction

  function automatic logic [VW-1:0] actual_out();
    return {m_bus.read, m_bus.write, m_bus.addr, m_bus.wdata,
            i_bus.ready, i_bus.rdata, d_bus.ready, d_bus.rdata};
  endfunction

  task automatic checkOutput(input string name, input int owner);
    logic [VW-1:0] act;
    logic [VW-1:0] req;
    act = actual_out();
    req = expect_out(owner);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s owner=%0d actual=%h required=%h", name, owner, act, req);
    end
  endtask

  task automatic applyStimulus(input logic ir, input logic iw, input logic dr, input logic dw,
                               input logic rdy, input logic [DATA_W-1:0] rdata);
    i_bus.read  = ir;
    i_bus.write = iw;
    d_bus.read  = dr;
    d_bus.write = dw;
    m_bus.ready = rdy;
    m_bus.rdata = rdata;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Ownership model: who holds the port after this cycle's rising edge.
  task automatic model_update();
    logic ia, da;
    ia = i_bus.read | i_bus.write;
    da = d_bus.read | d_bus.write;
    if (proc_reset) begin
      m_owner = OWN_NONE;
      m_last  = OWN_I;
    end else if (m_owner == OWN_NONE) begin
      if (ia && da) m_owner = RR_EN ? ((m_last == OWN_I) ? OWN_D : OWN_I) : OWN_D;
      else if (da)  m_owner = OWN_D;
      else if (ia)  m_owner = OWN_I;
      if (m_owner != OWN_NONE) m_last = m_owner;
    end else if (m_bus.ready || !((m_owner == OWN_I) ? ia : da)) begin
      m_owner = OWN_NONE;
    end
  endtask

  initial begin
    vec_t vecs[8];
    logic [DATA_W-1:0] a5;
    a5 = {16{8'hA5}};
    checks = 0;
    failures = 0;
    m_owner = OWN_NONE;
    m_last = OWN_I;

    proc_reset = 1'b1;
    i_bus.addr = '0; i_bus.wdata = '0;
    d_bus.addr = '0; d_bus.wdata = '0;
    applyStimulus(0, 0, 0, 0, 0, '0);
    step(); step();
    #1 checkOutput("reset", OWN_NONE);
    step();
    proc_reset = 1'b0;

    // Single I-cache read, memory answers four cycles after the request.
    i_bus.addr = 28'h0000010;
    applyStimulus(1, 0, 0, 0, 0, '0);
    #1 checkOutput("rd_idle", OWN_NONE);
    step(); #1 checkOutput("rd_grant", OWN_I);
    step(); #1 checkOutput("rd_wait1", OWN_I);
    step(); #1 checkOutput("rd_wait2", OWN_I);
    step(); applyStimulus(1, 0, 0, 0, 1, a5);
    #1 checkOutput("rd_ready", OWN_I);
    step(); applyStimulus(0, 0, 0, 0, 0, '0);
    #1 checkOutput("rd_after", OWN_NONE);

    // Arbitration table; history entering it is last grant = I.
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, OWN_D};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, RR_EN ? OWN_I : OWN_D};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, OWN_D};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, OWN_I};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, OWN_D};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, OWN_D};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, RR_EN ? OWN_I : OWN_D};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, OWN_I};
    i_bus.addr = 28'h0000020; i_bus.wdata = 128'h2;
    d_bus.addr = 28'h0000030; d_bus.wdata = 128'h1;
    for (int k = 0; k < 8; k++) begin
      step(); applyStimulus(vecs[k].ir, vecs[k].iw, vecs[k].dr, vecs[k].dw, 0, '0);
      #1 checkOutput($sformatf("tbl%0d_idle", k), OWN_NONE);
      step(); #1 checkOutput($sformatf("tbl%0d_grant", k), vecs[k].exp_owner);
      step(); applyStimulus(vecs[k].ir, vecs[k].iw, vecs[k].dr, vecs[k].dw, 1, rand_data());
      #1 checkOutput($sformatf("tbl%0d_ready", k), vecs[k].exp_owner);
      step(); applyStimulus(0, 0, 0, 0, 0, '0);
      #1 checkOutput($sformatf("tbl%0d_after", k), OWN_NONE);
    end

    // I requests while D is busy; it must wait and be granted two cycles after D completes.
    d_bus.addr = 28'h0000040;
    step(); applyStimulus(0, 0, 0, 1, 0, '0);
    #1 checkOutput("busy_idle", OWN_NONE);
    step(); #1 checkOutput("busy_grant_d", OWN_D);
    step(); applyStimulus(1, 0, 0, 1, 0, '0);
    #1 checkOutput("busy_i_waits", OWN_D);
    step(); applyStimulus(1, 0, 0, 1, 1, rand_data());
    #1 checkOutput("busy_d_ready", OWN_D);
    step(); applyStimulus(1, 0, 0, 0, 0, '0);
    #1 checkOutput("busy_gap", OWN_NONE);
    step(); #1 checkOutput("busy_i_granted", OWN_I);
    step(); applyStimulus(1, 0, 0, 0, 1, rand_data());
    #1 checkOutput("busy_i_ready", OWN_I);
    step(); applyStimulus(0, 0, 0, 0, 0, '0);
    #1 checkOutput("busy_after", OWN_NONE);

    // D withdraws its write before memory answers; the late completion goes nowhere.
    step(); applyStimulus(0, 0, 0, 1, 0, '0);
    #1 checkOutput("abort_idle", OWN_NONE);
    step(); #1 checkOutput("abort_grant", OWN_D);
    step(); applyStimulus(0, 0, 0, 0, 0, '0);
    #1 checkOutput("abort_drop", OWN_D);
    step(); applyStimulus(0, 0, 0, 0, 1, rand_data());
    #1 checkOutput("abort_late_ready", OWN_NONE);

    // Reset during an I grant, then a tie right after release.
    step(); applyStimulus(1, 0, 0, 0, 0, '0);
    #1 checkOutput("rst_idle0", OWN_NONE);
    step(); #1 checkOutput("rst_grant_i", OWN_I);
    step(); proc_reset = 1'b1;
    #1 checkOutput("rst_assert", OWN_I);
    step(); proc_reset = 1'b0; applyStimulus(1, 0, 1, 0, 1, rand_data());
    #1 checkOutput("rst_cleared", OWN_NONE);
    step(); applyStimulus(1, 0, 1, 0, 0, '0);
    #1 checkOutput("rst_tie_d", OWN_D);
    step(); applyStimulus(0, 0, 0, 0, 0, '0);

    // Randomized traffic against the ownership model, starting from a clean reset.
    step(); proc_reset = 1'b1;
    model_update();
    for (int n = 0; n < 600; n++) begin
      step();
      proc_reset  = ($urandom_range(0, 49) == 0);
      i_bus.read  = i_bus.read  ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 2);
      i_bus.write = i_bus.write ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 1);
      d_bus.read  = d_bus.read  ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 2);
      d_bus.write = d_bus.write ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) < 1);
      i_bus.addr  = ADDR_W'($urandom);
      d_bus.addr  = ADDR_W'($urandom);
      i_bus.wdata = rand_data();
      d_bus.wdata = rand_data();
      m_bus.ready = ($urandom_range(0, 3) == 0);
      m_bus.rdata = rand_data();
      #1 checkOutput("rand", m_owner);
      model_update();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single 128-bit main-memory interface between the instruction cache and the data cache. It sits between both cache `mem_*` ports and the memory model. It grants one cache at a time and forwards that cache's request and address, plus write data for writes, to memory. It steers `mem_rdata` and `mem_ready` back to the granted cache only, and holds the grant until memory completes the transaction.

## Interface
Parameters:
- `ADDR_W`, 28: block address width (word address >> 2).
- `DATA_W`, 128: block data width.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `proc_reset`  in  1  synchronous, active-high reset.
- `i_mem_read`, `i_mem_write`  in  1 each  I-cache request strobes (level, held until `i_mem_ready`).
- `i_mem_addr`  in  ADDR_W  I-cache block address.
- `i_mem_wdata`  in  DATA_W  I-cache write data.
- `i_mem_rdata`  out  DATA_W  read data to I-cache.
- `i_mem_ready`  out  1  completion to I-cache.
- `d_mem_read`, `d_mem_write`, `d_mem_addr`, `d_mem_wdata`, `d_mem_rdata`, `d_mem_ready`: same as the `i_` ports, for the D-cache.
- `mem_read`, `mem_write`  out  1 each  request to memory.
- `mem_addr`  out  ADDR_W  address to memory.
- `mem_wdata`  out  DATA_W  write data to memory.
- `mem_rdata`  in  DATA_W  memory read data, valid with `mem_ready`.
- `mem_ready`  in  1  memory completion pulse.

## Operation
- A requester is active when its `read | write` is high.
- FSM states:
  - IDLE:
    - No active requester: stay in IDLE.
    - Exactly one active: go to GNT_I or GNT_D for that requester.
    - Both active: resolve the tie per Configuration.
  - GNT_I / GNT_D:
    - Forward the granted side's `read`, `write`, `addr` and `wdata` to `mem_*`.
    - Return to IDLE on the cycle `mem_ready`=1 is sampled.
    - Also return to IDLE if the granted side drops both strobes without `mem_ready` (abort).
- Memory outputs in IDLE: `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- Return path:
  - `x_mem_ready` = `mem_ready` & (state==GNT_x), combinational.
  - `x_mem_rdata` = `mem_rdata` when granted to x, else 0.
  - The non-granted side always sees ready=0 and rdata=0.
- If both `read` and `write` are high on the granted side, both are forwarded unmodified; resolving this is the memory's concern.
- `last_gnt` register records the side most recently granted. It updates on entry to GNT_I/GNT_D.
- `mem_ready` seen in IDLE is ignored; nothing is forwarded.

## Timing
- Reset, applied synchronously on any cycle including mid-transaction:
  - state=IDLE, `last_gnt`=I.
  - All `mem_*` outputs 0; both `x_mem_ready` 0; both `x_mem_rdata` 0.
- Request sampled in IDLE in cycle N → grant registered → `mem_read`/`mem_write` high from cycle N+1.
- Arbitration latency is 1 cycle.
- `mem_ready` in cycle M reaches the granted cache combinationally in cycle M (0-cycle return). State is IDLE in M+1 with memory strobes low.
- Back-to-back requests: the earliest re-grant is M+2.
  - This guarantees at least one idle cycle on the memory port between transactions.
  - This applies to the D-cache write-back then allocate sequence as well.
- A request arriving while the other side is granted waits; its strobe stays high and it is never dropped.
- Addr/wdata changes on the granted side during a grant are forwarded live; caches must hold them stable.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Ties in IDLE go to the side NOT equal to `last_gnt` (round-robin).
  - After reset `last_gnt`=I, so the first tie grants D.
- `MEM_ARB_RR_EN` undefined:
  - Fixed priority; D always wins ties.
  - `last_gnt` is still maintained but unused for arbitration.
  - I-cache can starve under continuous D traffic; this is accepted.

## Test plan
- Single read: `i_mem_read`=1, `i_mem_addr`=28'h0000010 in IDLE; memory returns `mem_ready` with `mem_rdata`=128'hA5…A5 four cycles later.
  - Required: `mem_read`=1 and `mem_addr`=28'h0000010 from the next cycle.
  - Required: `i_mem_ready`=1 and `i_mem_rdata`=A5…A5 in the ready cycle.
  - Required: `d_mem_ready`=0 throughout; `mem_read`=0 the following cycle.
- Simultaneous requests with RR: I read 0x20 and D write 0x30 (`d_mem_wdata`=128'h1) asserted in the same cycle.
  - Required: D is served first (`mem_write`=1, `mem_addr`=0x30).
  - Required: I is served after D's `mem_ready` plus 1 idle cycle.
  - Next tie: I wins.
- Fixed priority (no macro): three consecutive tied I/D pairs → D is granted all three times.
- Wait while busy: D is granted; I asserts read mid-transaction → I's strobe is not forwarded, `i_mem_ready` stays 0, and I is granted exactly 2 cycles after D's `mem_ready`.
- Abort: granted D drops `d_mem_write` before `mem_ready` → state returns to IDLE next cycle and `mem_write`=0; a late `mem_ready` is not forwarded to either side.
- Reset mid-grant: `proc_reset`=1 during GNT_I → next cycle all outputs are 0 and state is IDLE; a tie after release grants D.
